neuron_calc: RTL and testbench

Compute engine directly downstream of avalon_interface. On start_calc it walks the pixel and weight SRAMs that avalon_interface fills, and multiply-accumulates each output neuron. It writes one saturated result per neuron back to the result store (result_output/output_address), then raises done_calc for the host to poll. It owns no memory; it only issues read addresses and consumes data with 1-cycle SRAM latency.

---
 rtl/nn_pkg.sv | 23 ++
 rtl/mac_sat.sv | 48 ++++
 rtl/neuron_calc.sv | 153 +++++++++++++++
 tb/tb_neuron_calc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared widths, saturation bounds and FSM state type for the neuron_calc engine.
package nn_pkg;

  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned PIXEL_W    = 8;
  localparam int unsigned WEIGHT_W   = 8;
  localparam int unsigned RESULT_W   = 17;
  localparam int unsigned OUT_IDX_W  = 4;
  localparam int unsigned PROD_W     = PIXEL_W + WEIGHT_W;
  localparam int unsigned ADDR_SPACE = 2048;

  localparam int SAT_MAX = 65535;
  localparam int SAT_MIN = -65536;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    STORE,
    DONE
  } calc_state_t;

endpackage

// File: rtl/mac_sat.sv
// Combinational u8 x s8 product (sign-extended to ACC_W) and store-time saturation.
// With NEURON_CALC_RELU_EN defined, negative accumulators store as zero.
module mac_sat
  import nn_pkg::*;
#(
  parameter int unsigned ACC_W = 24
) (
  input  logic        [PIXEL_W-1:0]  pixel,
  input  logic        [WEIGHT_W-1:0] weight,
  input  logic signed [ACC_W-1:0]    acc,
  output logic signed [ACC_W-1:0]    product_c,
  output logic signed [RESULT_W-1:0] result_c
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(SAT_MIN);

  if (ACC_W <= RESULT_W) begin : g_acc_too_narrow
    $error("mac_sat: ACC_W must exceed RESULT_W");
  end

  logic signed [PROD_W-1:0] px_ext;
  logic signed [PROD_W-1:0] wt_ext;
  logic signed [PROD_W-1:0] prod;

  // Pixel is unsigned, so it enters the multiply zero-extended.
  assign px_ext    = {{(PROD_W-PIXEL_W){1'b0}}, pixel};
  assign wt_ext    = {{(PROD_W-WEIGHT_W){weight[WEIGHT_W-1]}}, weight};
  assign prod      = px_ext * wt_ext;
  assign product_c = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_comb begin
    if (acc > ACC_MAX) begin
      result_c = RESULT_W'(SAT_MAX);
    end else if (acc < ACC_MIN) begin
      result_c = RESULT_W'(SAT_MIN);
    end else begin
      result_c = acc[RESULT_W-1:0];
    end
`ifdef NEURON_CALC_RELU_EN
    if (acc[ACC_W-1]) begin
      result_c = '0;
    end
`else
`endif
  end

endmodule

// File: rtl/neuron_calc.sv
// Neuron MAC engine: walks pixel/weight SRAMs, accumulates each neuron, stores saturated results.
// Optional build macro NEURON_CALC_RELU_EN clamps negative results to zero (timing unchanged).
module neuron_calc
  import nn_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = 64,
  parameter int unsigned NUM_OUTPUTS = 10,
  parameter int unsigned ACC_W       = 24
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start_calc,
  output logic [ADDR_W-1:0]     pixel_addr,
  input  logic [PIXEL_W-1:0]    pixel_data,
  output logic [ADDR_W-1:0]     weight_addr,
  input  logic [WEIGHT_W-1:0]   weight_data,
  output logic [RESULT_W-1:0]   result_output,
  output logic [OUT_IDX_W-1:0]  output_address,
  output logic                  result_wen,
  output logic                  busy,
  output logic                  done_calc
);

  localparam int unsigned WPTR_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0]    LAST_IN  = ADDR_W'(NUM_INPUTS - 1);
  localparam logic [OUT_IDX_W-1:0] LAST_OUT = OUT_IDX_W'(NUM_OUTPUTS - 1);

  if (NUM_INPUTS * NUM_OUTPUTS > ADDR_SPACE) begin : g_addr_overflow
    $error("neuron_calc: NUM_INPUTS*NUM_OUTPUTS exceeds weight address space");
  end
  if (NUM_INPUTS < 2 || NUM_OUTPUTS < 1 || NUM_OUTPUTS > 16) begin : g_bad_dims
    $error("neuron_calc: NUM_INPUTS/NUM_OUTPUTS out of range");
  end

  calc_state_t             state_q, state_d;
  logic [ADDR_W-1:0]       in_cnt_q, in_cnt_d;
  logic [OUT_IDX_W-1:0]    out_cnt_q, out_cnt_d;
  logic [WPTR_W-1:0]       wptr_q, wptr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    valid_q, valid_d;

  logic [ADDR_W-1:0]       pixel_addr_d, weight_addr_d;
  logic [RESULT_W-1:0]     result_output_d;
  logic [OUT_IDX_W-1:0]    output_address_d;
  logic                    result_wen_d, busy_d, done_calc_d;

  logic signed [ACC_W-1:0]    product_c;
  logic signed [RESULT_W-1:0] result_c;

  mac_sat #(
    .ACC_W (ACC_W)
  ) u_mac_sat (
    .pixel     (pixel_data),
    .weight    (weight_data),
    .acc       (acc_q),
    .product_c (product_c),
    .result_c  (result_c)
  );

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d          = state_q;
    in_cnt_d         = in_cnt_q;
    out_cnt_d        = out_cnt_q;
    wptr_d           = wptr_q;
    acc_d            = acc_q;
    valid_d          = (state_q == RUN);
    result_output_d  = result_output;
    output_address_d = output_address;
    result_wen_d     = 1'b0;

    // Data returns one cycle after each address issued in RUN.
    if (valid_q) begin
      acc_d = acc_q + product_c;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_calc) begin
          state_d   = RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          wptr_d    = '0;
          acc_d     = '0;
        end
      end
      RUN: begin
        in_cnt_d = in_cnt_q + ADDR_W'(1);
        wptr_d   = wptr_q + WPTR_W'(1);
        if (in_cnt_q == LAST_IN) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = STORE;
      end
      STORE: begin
        result_wen_d     = 1'b1;
        output_address_d = out_cnt_q;
        result_output_d  = result_c;
        acc_d            = '0;
        in_cnt_d         = '0;
        if (out_cnt_q == LAST_OUT) begin
          state_d = DONE;
        end else begin
          out_cnt_d = out_cnt_q + OUT_IDX_W'(1);
          state_d   = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pixel_addr_d  = (state_d == RUN) ? in_cnt_d : '0;
    weight_addr_d = (state_d == RUN) ? wptr_d[ADDR_W-1:0] : '0;
    busy_d        = (state_d == RUN) || (state_d == DRAIN) || (state_d == STORE);
    done_calc_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      wptr_q         <= '0;
      acc_q          <= '0;
      valid_q        <= 1'b0;
      pixel_addr     <= '0;
      weight_addr    <= '0;
      result_output  <= '0;
      output_address <= '0;
      result_wen     <= 1'b0;
      busy           <= 1'b0;
      done_calc      <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      wptr_q         <= wptr_d;
      acc_q          <= acc_d;
      valid_q        <= valid_d;
      pixel_addr     <= pixel_addr_d;
      weight_addr    <= weight_addr_d;
      result_output  <= result_output_d;
      output_address <= output_address_d;
      result_wen     <= result_wen_d;
      busy           <= busy_d;
      done_calc      <= done_calc_d;
    end
  end

endmodule

// File: tb/tb_neuron_calc.sv
// Self-checking bench for neuron_calc: directed and random SRAM images against a dot-product model.
module tb_neuron_calc;

  localparam int NI  = 64;
  localparam int NO  = 10;
  localparam int PER = NI + 2;

  logic        tb_clk;
  logic        n_rst;
  logic        start_calc;
  logic [10:0] pixel_addr;
  logic [7:0]  pixel_data;
  logic [10:0] weight_addr;
  logic [7:0]  weight_data;
  logic [16:0] result_output;
  logic [3:0]  output_address;
  logic        result_wen;
  logic        busy;
  logic        done_calc;

  int vectors;
  int miscompares;

  logic [7:0]  pix_mem [0:2047];
  logic [7:0]  w_mem   [0:2047];
  logic [16:0] exp_res [0:NO-1];

  neuron_calc #(
    .NUM_INPUTS  (NI),
    .NUM_OUTPUTS (NO),
    .ACC_W       (24)
  ) dut (
    .clk            (tb_clk),
    .n_rst          (n_rst),
    .start_calc     (start_calc),
    .pixel_addr     (pixel_addr),
    .pixel_data     (pixel_data),
    .weight_addr    (weight_addr),
    .weight_data    (weight_data),
    .result_output  (result_output),
    .output_address (output_address),
    .result_wen     (result_wen),
    .busy           (busy),
    .done_calc      (done_calc)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // SRAMs with one-cycle read latency.
  always @(posedge tb_clk) begin
    pixel_data  <= pix_mem[pixel_addr];
    weight_data <= w_mem[weight_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] ref_neuron(input int o);
    int s;
    int p;
    int w;
    s = 0;
    for (int i = 0; i < NI; i++) begin
      p = int'(pix_mem[i]);
      w = int'($signed(w_mem[o*NI + i]));
      s = s + p * w;
    end
    if (s > 65535) s = 65535;
    if (s < -65536) s = -65536;
`ifdef NEURON_CALC_RELU_EN
    if (s < 0) s = 0;
`endif
    return 17'(s);
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_paddr"}, 32'(pixel_addr), 32'd0);
    chk({tag, "_waddr"}, 32'(weight_addr), 32'd0);
    chk({tag, "_result"}, 32'(result_output), 32'd0);
    chk({tag, "_oaddr"}, 32'(output_address), 32'd0);
    chk({tag, "_wen"}, 32'(result_wen), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done_calc), 32'd0);
  endtask

  // One full calculation; start is re-pulsed at cycle repulse_at (0 = never).
  task automatic run_calc(input string tag, input int repulse_at);
    int  cyc;
    int  k;
    bit  seen_done;
    for (int o = 0; o < NO; o++) exp_res[o] = ref_neuron(o);
    @(posedge tb_clk); #1 start_calc = 1'b1;
    @(posedge tb_clk); #1 start_calc = 1'b0;
    cyc = 0;
    k = 0;
    seen_done = 1'b0;
    chk({tag, "_done_drop"}, 32'(done_calc), 32'd0);
    chk({tag, "_busy_on"}, 32'(busy), 32'd1);
    while (cyc < 2000 && !seen_done) begin
      @(posedge tb_clk); #1;
      cyc++;
      start_calc = (cyc == repulse_at);
      if (result_wen) begin
        chk({tag, "_wen_time"}, 32'(cyc), 32'((k + 1) * PER));
        chk({tag, "_oaddr"}, 32'(output_address), 32'(k));
        if (k < NO) chk({tag, "_result"}, 32'(result_output), 32'(exp_res[k]));
        k++;
      end
      if (done_calc) begin
        seen_done = 1'b1;
        chk({tag, "_done_time"}, 32'(cyc), 32'(NO * PER));
        chk({tag, "_wen_count"}, 32'(k), 32'(NO));
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
      end
    end
    start_calc = 1'b0;
    if (!seen_done) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    @(posedge tb_clk); #1;
    chk({tag, "_done_hold"}, 32'(done_calc), 32'd1);
    chk({tag, "_result_hold"}, 32'(result_output), 32'(exp_res[NO-1]));
  endtask

  initial begin
    bit any_wen;
    bit any_busy;
    vectors     = 0;
    miscompares = 0;
    n_rst       = 1'b0;
    start_calc  = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      pix_mem[i] = 8'd0;
      w_mem[i]   = 8'd0;
    end
    repeat (3) @(posedge tb_clk);
    #1;
    check_outputs_zero("reset");
    n_rst = 1'b1;
    repeat (2) @(posedge tb_clk);
    #1;
    check_outputs_zero("idle");

    // All ones: every neuron sums to NI.
    for (int i = 0; i < NI * NO; i++) begin
      pix_mem[i % NI] = 8'd1;
      w_mem[i]        = 8'd1;
    end
    run_calc("ones", 0);

    // Weight equals neuron index, pixels 2: exposes the per-neuron weight stride.
    for (int o = 0; o < NO; o++)
      for (int i = 0; i < NI; i++) begin
        pix_mem[i]       = 8'd2;
        w_mem[o*NI + i]  = 8'(o);
      end
    run_calc("stride", 0);

    // Positive saturation.
    for (int i = 0; i < NI * NO; i++) begin
      pix_mem[i % NI] = 8'd255;
      w_mem[i]        = 8'd127;
    end
    run_calc("satpos", 100);

    // Negative saturation (or zero under ReLU).
    for (int i = 0; i < NI * NO; i++) w_mem[i] = 8'h80;
    run_calc("satneg", 0);

    // Random full-range image and weights.
    for (int i = 0; i < NI; i++) pix_mem[i] = 8'($urandom);
    for (int i = 0; i < NI * NO; i++) w_mem[i] = 8'($urandom);
    run_calc("rand_full", 0);

    // Random small weights keep most sums in range.
    for (int i = 0; i < NI; i++) pix_mem[i] = 8'($urandom);
    for (int i = 0; i < NI * NO; i++) w_mem[i] = 8'($urandom_range(0, 15) - 8);
    run_calc("rand_small", 37);

    // Reset mid-calculation aborts with no further writes.
    @(posedge tb_clk); #1 start_calc = 1'b1;
    @(posedge tb_clk); #1 start_calc = 1'b0;
    repeat (299) @(posedge tb_clk);
    #1 n_rst = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (3) @(posedge tb_clk);
    #1 n_rst = 1'b1;
    any_wen  = 1'b0;
    any_busy = 1'b0;
    repeat (200) begin
      @(posedge tb_clk); #1;
      any_wen  = any_wen | result_wen;
      any_busy = any_busy | busy | done_calc;
    end
    chk("abort_no_wen", 32'(any_wen), 32'd0);
    chk("abort_no_resume", 32'(any_busy), 32'd0);

    // Fresh start from IDLE after the abort.
    run_calc("post_reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
